row_plot_sequencer: RTL and testbench

- Sequences shifter_128bit to draw NUM_ROWS bitmap rows onto the VGA adapter.
- Per row: fetches one ROW_BITS-wide row from bitmap memory (req/ack), loads the shifter, then shifts it out MSB-first.
- Emits one plot per bit with x/y coordinates and colour.
- Sits between the notepad text/bitmap store and the VGA adapter.

---
 rtl/row_plot_pkg.sv | 33 +++
 rtl/row_plot_addr_gen.sv | 83 ++++++++
 rtl/row_plot_sequencer.sv | 176 +++++++++++++++++
 tb/tb_row_plot_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_plot_pkg.sv
// -----------------------------------------------------------------------------
// row_plot_pkg
// Shared types and default sizes for the row plot sequencer.
//   - state_e   : sequencer FSM states
//   - DEF_*     : default parameter values (128-bit rows, 8 rows, 8/7-bit x/y,
//                 3-bit colour)
//   - idx_w()   : index width for a count, never less than 1 bit
// Optional feature macro used by the top level: SKIP_BLANK_ROW_EN.
// -----------------------------------------------------------------------------
package row_plot_pkg;

  localparam int DEF_ROW_BITS = 128;
  localparam int DEF_NUM_ROWS = 8;
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COL_W    = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_IDX_W = idx_w(DEF_NUM_ROWS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/row_plot_addr_gen.sv
// -----------------------------------------------------------------------------
// row_plot_addr_gen
// Row and bit counters plus the wrapping x/y coordinate adders.
// Ports:
//   clock, reset      : clock, async active-low reset
//   cfg_load_i        : capture x_base_i / y_base_i
//   row_clr_i/inc_i   : clear / advance the row counter
//   k_clr_i/inc_i     : clear / advance the bit counter
//   row_o             : current row index
//   last_row_o/last_k_o : counters at their final value
//   x_o, y_o          : base + counter, truncated to X_W / Y_W (wraps)
// -----------------------------------------------------------------------------
module row_plot_addr_gen
  import row_plot_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cfg_load_i,
  input  logic [X_W-1:0]               x_base_i,
  input  logic [Y_W-1:0]               y_base_i,
  input  logic                         row_clr_i,
  input  logic                         row_inc_i,
  input  logic                         k_clr_i,
  input  logic                         k_inc_i,
  output logic [idx_w(NUM_ROWS)-1:0]   row_o,
  output logic                         last_row_o,
  output logic                         last_k_o,
  output logic [X_W-1:0]               x_o,
  output logic [Y_W-1:0]               y_o
);

  localparam int RW = idx_w(NUM_ROWS);
  localparam int KW = idx_w(ROW_BITS);
  // Sum widths one bit wider than either operand; the top bit is dropped to wrap.
  localparam int XS = ((X_W > KW) ? X_W : KW) + 1;
  localparam int YS = ((Y_W > RW) ? Y_W : RW) + 1;

  logic [RW-1:0]  row_q, row_d;
  logic [KW-1:0]  k_q, k_d;
  logic [X_W-1:0] x_base_q;
  logic [Y_W-1:0] y_base_q;
  logic [XS-1:0]  x_sum;
  logic [YS-1:0]  y_sum;

  always_comb begin
    row_d = row_q;
    if (row_clr_i)      row_d = '0;
    else if (row_inc_i) row_d = row_q + 1'b1;
    k_d = k_q;
    if (k_clr_i)        k_d = '0;
    else if (k_inc_i)   k_d = k_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q    <= '0;
      k_q      <= '0;
      x_base_q <= '0;
      y_base_q <= '0;
    end else begin
      row_q <= row_d;
      k_q   <= k_d;
      if (cfg_load_i) begin
        x_base_q <= x_base_i;
        y_base_q <= y_base_i;
      end
    end
  end

  assign x_sum      = XS'(x_base_q) + XS'(k_q);
  assign y_sum      = YS'(y_base_q) + YS'(row_q);
  assign x_o        = x_sum[X_W-1:0];
  assign y_o        = y_sum[Y_W-1:0];
  assign row_o      = row_q;
  assign last_row_o = (row_q == RW'(NUM_ROWS - 1));
  assign last_k_o   = (k_q == KW'(ROW_BITS - 1));

endmodule

// File: rtl/row_plot_sequencer.sv
// -----------------------------------------------------------------------------
// row_plot_sequencer
// Draws NUM_ROWS bitmap rows: fetches each row from memory, loads it into an
// external 128-bit shifter and shifts it out MSB-first, one VGA plot per bit.
// Ports:
//   clock, reset              : clock, async active-low reset
//   start, busy, done         : 1-cycle request / activity flag / end pulse
//   x_base, y_base            : block origin, sampled at start
//   fg_colour, bg_colour      : colours for 1 / 0 bits, sampled at start
//   mem_req/addr/ack/data     : row fetch handshake
//   sh_load_val/load_n/shift/reset, sh_result : external shifter control
//   vga_x/y/colour/plot       : plot outputs
// Build option: define SKIP_BLANK_ROW_EN to skip rows fetched as all zeros.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | shifter cleared (sh_reset low), row counter zeroed
// FETCH  | mem_req held until mem_ack, row data latched
// LOAD   | shifter loads the latched row
// SHIFT  | one bit shifted and plotted per cycle
// DONE   | done pulse, back to IDLE
// -----------------------------------------------------------------------------
module row_plot_sequencer
  import row_plot_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COL_W    = DEF_COL_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [X_W-1:0]             x_base,
  input  logic [Y_W-1:0]             y_base,
  input  logic [COL_W-1:0]           fg_colour,
  input  logic [COL_W-1:0]           bg_colour,
  output logic                       mem_req,
  output logic [idx_w(NUM_ROWS)-1:0] mem_addr,
  input  logic                       mem_ack,
  input  logic [ROW_BITS-1:0]        mem_data,
  output logic [ROW_BITS-1:0]        sh_load_val,
  output logic                       sh_load_n,
  output logic                       sh_shift,
  output logic                       sh_reset,
  input  logic                       sh_result,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [COL_W-1:0]           vga_colour,
  output logic                       vga_plot,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = idx_w(NUM_ROWS);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    fg_q, bg_q;
  logic [ROW_BITS-1:0] load_val_q;
  logic                cfg_load, row_clr, row_inc, k_clr, k_inc, data_load;
  logic                row_blank, last_row, last_k;
  logic [RW-1:0]       row;
  logic [X_W-1:0]      x_pos;
  logic [Y_W-1:0]      y_pos;

`ifdef SKIP_BLANK_ROW_EN
  assign row_blank = (mem_data == '0);
`else
  assign row_blank = 1'b0;
`endif

  row_plot_addr_gen #(
    .ROW_BITS (ROW_BITS),
    .NUM_ROWS (NUM_ROWS),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_addr_gen (
    .clock      (clock),
    .reset      (reset),
    .cfg_load_i (cfg_load),
    .x_base_i   (x_base),
    .y_base_i   (y_base),
    .row_clr_i  (row_clr),
    .row_inc_i  (row_inc),
    .k_clr_i    (k_clr),
    .k_inc_i    (k_inc),
    .row_o      (row),
    .last_row_o (last_row),
    .last_k_o   (last_k),
    .x_o        (x_pos),
    .y_o        (y_pos)
  );

  always_comb begin
    state_d   = state_q;
    cfg_load  = 1'b0;
    row_clr   = 1'b0;
    row_inc   = 1'b0;
    k_clr     = 1'b0;
    k_inc     = 1'b0;
    data_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_load = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        row_clr = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack) begin
          data_load = 1'b1;
          if (!row_blank) begin
            state_d = ST_LOAD;
          end else if (last_row) begin
            state_d = ST_DONE;
          end else begin
            row_inc = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        k_clr   = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        k_inc = 1'b1;
        if (last_k) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            row_inc = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fg_q       <= '0;
      bg_q       <= '0;
      load_val_q <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        fg_q <= fg_colour;
        bg_q <= bg_colour;
      end
      if (data_load) load_val_q <= mem_data;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign mem_req     = (state_q == ST_FETCH);
  assign mem_addr    = mem_req ? row : '0;
  assign sh_load_val = load_val_q;
  assign sh_load_n   = (state_q == ST_LOAD);
  assign sh_shift    = (state_q == ST_SHIFT);
  // Held low by the async reset itself so the shifter clears while reset is asserted.
  assign sh_reset    = reset & (state_q != ST_CLEAR);
  assign vga_plot    = (state_q == ST_SHIFT);
  assign vga_x       = vga_plot ? x_pos : '0;
  assign vga_y       = vga_plot ? y_pos : '0;
  assign vga_colour  = vga_plot ? (sh_result ? fg_q : bg_q) : '0;

endmodule

// File: tb/tb_row_plot_sequencer.sv
module tb_row_plot_sequencer;

  localparam int RB = 128;
  localparam int NR = 2;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    x_base = '0;
  logic [6:0]    y_base = '0;
  logic [2:0]    fg_colour = '0;
  logic [2:0]    bg_colour = '0;
  logic          mem_req;
  logic [0:0]    mem_addr;
  logic          mem_ack = 1'b0;
  logic [RB-1:0] mem_data = '0;
  logic [RB-1:0] sh_load_val;
  logic          sh_load_n, sh_shift, sh_reset, sh_result;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot, busy, done;

  logic [RB-1:0] rows [NR];
  int            dly  [NR];
  plot_t         exp_q[$];
  plot_t         got_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [RB-1:0] sh_q;

  row_plot_sequencer #(
    .ROW_BITS (RB), .NUM_ROWS (NR), .X_W (8), .Y_W (7), .COL_W (3)
  ) dut (
    .clock (clock), .reset (reset), .start (start),
    .x_base (x_base), .y_base (y_base),
    .fg_colour (fg_colour), .bg_colour (bg_colour),
    .mem_req (mem_req), .mem_addr (mem_addr), .mem_ack (mem_ack), .mem_data (mem_data),
    .sh_load_val (sh_load_val), .sh_load_n (sh_load_n), .sh_shift (sh_shift),
    .sh_reset (sh_reset), .sh_result (sh_result),
    .vga_x (vga_x), .vga_y (vga_y), .vga_colour (vga_colour), .vga_plot (vga_plot),
    .busy (busy), .done (done)
  );

  always #5 clock = ~clock;

  // Behavioural shifter_128bit: sync active-low clear, load, shift left.
  always @(posedge clock) begin
    if (!sh_reset)      sh_q <= '0;
    else if (sh_load_n) sh_q <= sh_load_val;
    else if (sh_shift)  sh_q <= {sh_q[RB-2:0], 1'b0};
  end
  assign sh_result = sh_q[RB-1];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Memory: acks after dly[row] wait cycles in FETCH.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req) begin
        if (wcnt >= dly[mem_addr]) begin
          mem_ack  = 1'b1;
          mem_data = rows[mem_addr];
          wcnt     = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Monitor: every plot is popped from the scoreboard and compared.
  always @(negedge clock) begin
    plot_t g;
    plot_t e;
    if (reset && vga_plot) begin
      g = '{x: vga_x, y: vga_y, c: vga_colour};
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot", vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if (g !== e)
          $display("FAIL plot: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   g.x, g.y, g.c, e.x, e.y, e.c);
        n_checks++;
        if (g !== e) n_fail++;
      end
    end
    if (sh_load_n || sh_shift)
      chk("load_shift_exclusive", int'(sh_load_n & sh_shift), 0);
    if (mem_req)
      chk("no_plot_while_fetch", int'(vga_plot), 0);
  end

  task automatic push_expected();
    for (int r = 0; r < NR; r++) begin
`ifdef SKIP_BLANK_ROW_EN
      if (rows[r] == '0) continue;
`endif
      for (int k = 0; k < RB; k++) begin
        plot_t         p;
        logic [RB-1:0] d;
        d   = rows[r];
        p.x = 8'((int'(x_base) + k) % 256);
        p.y = 7'((int'(y_base) + r) % 128);
        p.c = d[RB-1-k] ? fg_colour : bg_colour;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic start_and_check_entry();
    @(posedge clock); #2 start = 1'b1;
    @(posedge clock); #2 start = 1'b0;
    chk("clear_state", int'({busy, mem_req, sh_reset}), 4);
    @(posedge clock); #2;
    chk("fetch_row0", int'({mem_req, mem_addr}), 2);
  endtask

  task automatic run_draw(input bit poke_mid, input bit poke_done, output int cycles);
    int  fetch1;
    int  extra;
    int  n_exp;
    bit  seen;
    got_q.delete();
    push_expected();
    n_exp = exp_q.size();
    start_and_check_entry();
    cycles = 0;
    fetch1 = 0;
    seen   = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (mem_req && mem_addr == 1'b1) fetch1++;
      if (done) begin
        seen = 1'b1;
      end else begin
        start = poke_mid && (c == 60);
        @(posedge clock); #2;
        cycles++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (poke_done) start = 1'b1;
      @(posedge clock); #2;
      start = 1'b0;
      chk("busy_after_done", int'({busy, done}), 0);
      extra = 0;
      repeat (6) begin
        @(posedge clock); #2;
        if (busy || done) extra++;
      end
      chk("idle_after_done", extra, 0);
    end
    chk("fetch_row1_cycles", fetch1, dly[1] + 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("plot_count", got_q.size(), n_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   ca;
    int   cb;
    int   cw;
    logic [7:0] x40;
    bit   hit;
    rows[0] = '0;
    rows[1] = '0;
    dly[0]  = 1;
    dly[1]  = 1;

    repeat (3) @(posedge clock);
    #2;
    chk("reset_ctrl", int'({busy, done, mem_req, vga_plot, sh_reset, sh_load_n, sh_shift}), 0);
    chk("reset_vga", int'({vga_x, vga_y, vga_colour, mem_addr}), 0);
    chk("reset_load_val", int'(sh_load_val != '0), 0);
    reset = 1'b1;
    #1;
    chk("after_reset", int'({sh_reset, busy}), 2);

    // Basic draw: row0 MSB only, row1 all ones.
    x_base = 8'd10; y_base = 7'd5; fg_colour = 3'd7; bg_colour = 3'd0;
    rows[0] = '0;
    rows[0][RB-1] = 1'b1;
    rows[1] = '1;
    run_draw(1'b0, 1'b0, ca);
    if (got_q.size() == 256) begin
      chk("basic_first",  int'(got_q[0]),   int'(plot_t'{8'd10,  7'd5, 3'd7}));
      chk("basic_second", int'(got_q[1]),   int'(plot_t'{8'd11,  7'd5, 3'd0}));
      chk("basic_row0_end", int'(got_q[127]), int'(plot_t'{8'd137, 7'd5, 3'd0}));
      chk("basic_row1_start", int'(got_q[128]), int'(plot_t'{8'd10, 7'd6, 3'd7}));
      chk("basic_last",   int'(got_q[255]), int'(plot_t'{8'd137, 7'd6, 3'd7}));
    end
    chk("basic_cycles", ca, 2 + 1 + RB + 2 + 1 + RB);

    // Memory stall of 20 extra cycles on row1.
    dly[1] = 21;
    run_draw(1'b0, 1'b0, cb);
    chk("stall_growth", cb - ca, 20);
    dly[1] = 1;

    // Wrap of x and y.
    x_base = 8'd200; y_base = 7'd127; fg_colour = 3'd2; bg_colour = 3'd5;
    rows[0] = {32{4'hA}};
    rows[1] = {32{4'h3}};
    run_draw(1'b0, 1'b0, cw);
    if (got_q.size() == 256) begin
      chk("wrap_x0",  int'(got_q[56]),  int'(plot_t'{8'd0, 7'd127, 3'd2}));
      chk("wrap_x55", int'(got_q[55]),  int'(plot_t'{8'd255, 7'd127, 3'd5}));
      chk("wrap_y0",  int'(got_q[128]), int'(plot_t'{8'd200, 7'd0, 3'd5}));
    end

    // Start pulses mid-SHIFT and in the DONE cycle are ignored.
    x_base = 8'd20; y_base = 7'd40; fg_colour = 3'd4; bg_colour = 3'd1;
    rows[0] = {16{8'h81}};
    rows[1] = {8{16'h00FF}};
    run_draw(1'b1, 1'b1, cw);

    // Async reset at k=40 of row0, then a fresh draw.
    x_base = 8'd30; y_base = 7'd10; fg_colour = 3'd3; bg_colour = 3'd6;
    got_q.delete();
    push_expected();
    start_and_check_entry();
    x40 = 8'd70;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(posedge clock); #2;
      if (vga_plot && vga_x == x40 && vga_y == 7'd10) hit = 1'b1;
    end
    chk("reached_k40", int'(hit), 1);
    reset = 1'b0;
    #1;
    chk("abort_ctrl", int'({busy, done, mem_req, vga_plot, sh_reset, sh_load_n, sh_shift}), 0);
    @(posedge clock); #2;
    chk("abort_next_edge", int'({busy, mem_req, vga_plot, sh_reset, vga_x}), 0);
    exp_q.delete();
    reset = 1'b1;
    run_draw(1'b0, 1'b0, cw);

    // Blank row handling.
    x_base = 8'd0; y_base = 7'd0; fg_colour = 3'd6; bg_colour = 3'd1;
    rows[0] = '0;
    rows[1] = '0;
    rows[1][0] = 1'b1;
    run_draw(1'b0, 1'b0, cw);
`ifdef SKIP_BLANK_ROW_EN
    chk("skip_plot_count", got_q.size(), 128);
    if (got_q.size() == 128)
      chk("skip_last", int'(got_q[127]), int'(plot_t'{8'd127, 7'd1, 3'd6}));
`else
    chk("noskip_plot_count", got_q.size(), 256);
    if (got_q.size() == 256) begin
      chk("noskip_row0", int'(got_q[0]),   int'(plot_t'{8'd0, 7'd0, 3'd1}));
      chk("noskip_last", int'(got_q[255]), int'(plot_t'{8'd127, 7'd1, 3'd6}));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
